// File: rtl/gps_nav_frame_tx.sv
// Captures position/velocity samples and serializes each launched sample as an
// 11-byte frame (sync, seq, position, velocity, checksum) on a valid/ready byte stream.
module gps_nav_frame_tx #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned DECIM     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] position,
  input  logic [31:0] velocity,
  input  logic        sample_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [7:0]  seq,
  output logic [15:0] frames_sent,
  output logic [15:0] drop_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  localparam logic [7:0] DECIM_LAST = 8'(DECIM - 1);
  localparam logic [3:0] LAST_IDX   = 4'd10;

  logic [0:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  dcnt_q, dcnt_d;
  logic [7:0]  seq_q, seq_d;
  logic [7:0]  sseq_q, sseq_d;
  logic [31:0] pos_q, pos_d;
  logic [31:0] vel_q, vel_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic [15:0] frames_q, frames_d;
  logic [15:0] drop_q, drop_d;
  logic        launch, hs;

  function automatic logic [7:0] checksum(input logic [7:0] s, input logic [31:0] p,
                                          input logic [31:0] v);
    checksum = s + p[31:24] + p[23:16] + p[15:8] + p[7:0]
                 + v[31:24] + v[23:16] + v[15:8] + v[7:0];
  endfunction

  function automatic logic [7:0] frame_byte(input logic [3:0] i, input logic [7:0] s,
                                            input logic [31:0] p, input logic [31:0] v);
    case (i)
      4'd0:    frame_byte = SYNC_BYTE;
      4'd1:    frame_byte = s;
      4'd2:    frame_byte = p[31:24];
      4'd3:    frame_byte = p[23:16];
      4'd4:    frame_byte = p[15:8];
      4'd5:    frame_byte = p[7:0];
      4'd6:    frame_byte = v[31:24];
      4'd7:    frame_byte = v[23:16];
      4'd8:    frame_byte = v[15:8];
      4'd9:    frame_byte = v[7:0];
      4'd10:   frame_byte = checksum(s, p, v);
      default: frame_byte = 8'h00;
    endcase
  endfunction

  assign launch = sample_valid && (dcnt_q == 8'd0);
  assign hs     = tx_valid_q && tx_ready;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dcnt_d     = dcnt_q;
    seq_d      = seq_q;
    sseq_d     = sseq_q;
    pos_d      = pos_q;
    vel_d      = vel_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    frames_d   = frames_q;
    drop_d     = drop_q;

    // Decimation advances on every strobe, independent of frame activity.
    if (sample_valid) begin
      dcnt_d = (dcnt_q == DECIM_LAST) ? 8'd0 : dcnt_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (launch) begin
          pos_d      = position;
          vel_d      = velocity;
          sseq_d     = seq_q;
          seq_d      = seq_q + 8'd1;
          idx_d      = 4'd0;
          tx_valid_d = 1'b1;
          tx_data_d  = SYNC_BYTE;
          state_d    = SEND;
        end
      end
      SEND: begin
        // Launches during a frame, including its final handshake cycle, are lost.
        if (launch && (drop_q != 16'hFFFF)) begin
          drop_d = drop_q + 16'd1;
        end
        if (hs) begin
          if (idx_q == LAST_IDX) begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
            frames_d   = frames_q + 16'd1;
          end else begin
            idx_d     = idx_q + 4'd1;
            tx_data_d = frame_byte(idx_q + 4'd1, sseq_q, pos_q, vel_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 4'd0;
      dcnt_q     <= 8'd0;
      seq_q      <= 8'd0;
      sseq_q     <= 8'd0;
      pos_q      <= 32'd0;
      vel_q      <= 32'd0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      frames_q   <= 16'd0;
      drop_q     <= 16'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      dcnt_q     <= dcnt_d;
      seq_q      <= seq_d;
      sseq_q     <= sseq_d;
      pos_q      <= pos_d;
      vel_q      <= vel_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      frames_q   <= frames_d;
      drop_q     <= drop_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign busy        = (state_q == SEND);
  assign seq         = seq_q;
  assign frames_sent = frames_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_gps_nav_frame_tx.sv
// Bench for gps_nav_frame_tx: two instances (DECIM=1 and DECIM=3) share stimulus and
// are compared every cycle against a frame-level model, plus literal frame checks.
module tb_gps_nav_frame_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pos, vel;
  logic        sv, rdy;
  logic [7:0]  txd[2];
  logic        txv[2];
  logic        bsy[2];
  logic [7:0]  sq[2];
  logic [15:0] frm[2];
  logic [15:0] drp[2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gps_nav_frame_tx #(.SYNC_BYTE(8'hA5), .DECIM(1)) u_dut1 (
    .clk(clk), .rst(rst), .position(pos), .velocity(vel), .sample_valid(sv),
    .tx_data(txd[0]), .tx_valid(txv[0]), .tx_ready(rdy), .busy(bsy[0]),
    .seq(sq[0]), .frames_sent(frm[0]), .drop_cnt(drp[0]));

  gps_nav_frame_tx #(.SYNC_BYTE(8'hA5), .DECIM(3)) u_dut3 (
    .clk(clk), .rst(rst), .position(pos), .velocity(vel), .sample_valid(sv),
    .tx_data(txd[1]), .tx_valid(txv[1]), .tx_ready(rdy), .busy(bsy[1]),
    .seq(sq[1]), .frames_sent(frm[1]), .drop_cnt(drp[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: a frame is a list of 11 bytes; "remaining" bytes > 0 means busy.
  int          mrem[2];
  logic [7:0]  mbuf[2][11];
  logic [7:0]  mseq[2];
  int          mdcnt[2];
  logic [15:0] mframes[2];
  logic [15:0] mdrop[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mrem[k] = 0; mseq[k] = 8'd0; mdcnt[k] = 0; mframes[k] = 16'd0; mdrop[k] = 16'd0;
    end
  endtask

  task automatic model_step(input int k);
    int  d;
    bit  was_busy;
    int  sum;
    d = (k == 0) ? 1 : 3;
    was_busy = (mrem[k] != 0);
    if (was_busy && rdy) begin
      mrem[k]--;
      if (mrem[k] == 0) mframes[k] = mframes[k] + 16'd1;
    end
    if (sv) begin
      if (mdcnt[k] == 0) begin
        if (was_busy) begin
          if (mdrop[k] != 16'hFFFF) mdrop[k] = mdrop[k] + 16'd1;
        end else begin
          mbuf[k][0] = 8'hA5;
          mbuf[k][1] = mseq[k];
          for (int i = 0; i < 4; i++) begin
            mbuf[k][2 + i] = 8'((pos >> (8 * (3 - i))) & 32'hFF);
            mbuf[k][6 + i] = 8'((vel >> (8 * (3 - i))) & 32'hFF);
          end
          sum = 0;
          for (int i = 1; i < 10; i++) sum += int'(mbuf[k][i]);
          mbuf[k][10] = 8'(sum % 256);
          mrem[k] = 11;
          mseq[k] = mseq[k] + 8'd1;
        end
      end
      mdcnt[k] = (mdcnt[k] + 1) % d;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("cyc_valid[%0d]", k), 32'(txv[k]), 32'(mrem[k] != 0));
        check($sformatf("cyc_busy[%0d]", k), 32'(bsy[k]), 32'(mrem[k] != 0));
        check($sformatf("cyc_seq[%0d]", k), 32'(sq[k]), 32'(mseq[k]));
        check($sformatf("cyc_frames[%0d]", k), 32'(frm[k]), 32'(mframes[k]));
        check($sformatf("cyc_drop[%0d]", k), 32'(drp[k]), 32'(mdrop[k]));
        if (mrem[k] != 0)
          check($sformatf("cyc_data[%0d]", k), 32'(txd[k]), 32'(mbuf[k][11 - mrem[k]]));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; sv = 1'b0; rdy = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  logic [7:0] exp_basic[11];
  logic [7:0] exp_bp[11];
  logic [7:0] got[11];
  logic [7:0] b256, b257;
  int n;

  initial begin
    exp_basic = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h03, 8'hE8, 8'h00, 8'h00, 8'h00, 8'h05, 8'hF0};
    exp_bp    = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h03, 8'hE8, 8'h00, 8'h00, 8'h00, 8'h05, 8'hF1};
    rst = 1'b1; sv = 1'b0; rdy = 1'b1; pos = 32'd0; vel = 32'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_valid", 32'(txv[0]), 32'd0);
    check("rst_data", 32'(txd[0]), 32'h00);
    check("rst_busy", 32'(bsy[0]), 32'd0);
    check("rst_seq", 32'(sq[0]), 32'd0);
    check("rst_frames", 32'(frm[0]), 32'd0);
    check("rst_drop", 32'(drp[0]), 32'd0);

    // Basic frame, inputs scrambled under the frame
    pos = 32'd1000; vel = 32'd5; sv = 1'b1;
    tick();
    sv = 1'b0;
    for (int i = 0; i < 11; i++) begin
      check($sformatf("basic_valid[%0d]", i), 32'(txv[0]), 32'd1);
      check($sformatf("basic_byte[%0d]", i), 32'(txd[0]), 32'(exp_basic[i]));
      pos = $urandom; vel = $urandom;
      tick();
    end
    check("basic_end_valid", 32'(txv[0]), 32'd0);
    check("basic_frames", 32'(frm[0]), 32'd1);
    check("basic_seq", 32'(sq[0]), 32'd1);

    // Backpressure with ready pattern 1,0,0
    pos = 32'd1000; vel = 32'd5; sv = 1'b1;
    tick();
    sv = 1'b0; pos = $urandom; vel = $urandom;
    n = 0;
    for (int c = 0; c < 45; c++) begin
      rdy = (c % 3 == 0);
      if (txv[0] && rdy && n < 11) begin
        got[n] = txd[0];
        n++;
      end
      tick();
    end
    rdy = 1'b1;
    check("bp_count", 32'(n), 32'd11);
    for (int i = 0; i < 11; i++)
      check($sformatf("bp_byte[%0d]", i), 32'(got[i]), 32'(exp_bp[i]));
    check("bp_frames", 32'(frm[0]), 32'd2);

    // Drops while busy, including on the final-byte handshake cycle
    do_reset();
    pos = 32'h11223344; vel = 32'h55667788;
    for (int c = 0; c < 16; c++) begin
      if (c == 12) begin
        check("drop_cnt", 32'(drp[0]), 32'd2);
        check("drop_frames", 32'(frm[0]), 32'd1);
        check("drop_seq", 32'(sq[0]), 32'd1);
        check("drop_busy", 32'(bsy[0]), 32'd0);
      end
      if (c == 14) check("drop_next_seq_byte", 32'(txd[0]), 32'h01);
      sv = (c == 0 || c == 3 || c == 11 || c == 12);
      tick();
    end
    sv = 1'b0;
    repeat (12) tick();

    // Decimation on the DECIM=3 instance
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      pos = $urandom; vel = $urandom; sv = 1'b1;
      tick();
      sv = 1'b0;
      check($sformatf("decim_busy[%0d]", k), 32'(bsy[1]), 32'(k % 3 == 1));
      tick();
      if (k % 3 == 1) check($sformatf("decim_seq[%0d]", k), 32'(txd[1]), 32'((k - 1) / 3));
      repeat (18) tick();
    end
    check("decim_frames", 32'(frm[1]), 32'd3);
    check("decim_drop", 32'(drp[1]), 32'd0);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      sv  = ($urandom % 5 == 0);
      rdy = ($urandom % 4 != 0);
      pos = $urandom; vel = $urandom;
      tick();
    end
    sv = 1'b0; rdy = 1'b1;
    repeat (15) tick();

    // Sequence wrap
    do_reset();
    b256 = 8'h00; b257 = 8'hFF;
    for (int f = 1; f <= 257; f++) begin
      pos = 32'(f); vel = $urandom; sv = 1'b1;
      tick();
      sv = 1'b0;
      tick();
      if (f == 256) b256 = txd[0];
      if (f == 257) b257 = txd[0];
      repeat (10) tick();
    end
    check("wrap_seq_256", 32'(b256), 32'hFF);
    check("wrap_seq_257", 32'(b257), 32'h00);
    check("wrap_frames", 32'(frm[0]), 32'd257);

    // Reset mid-frame
    pos = 32'hCAFEF00D; vel = 32'h12345678; sv = 1'b1;
    tick();
    sv = 1'b0;
    repeat (4) tick();
    check("mid_byte4", 32'(txd[0]), 32'hF0);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(txv[0]), 32'd0);
    check("mid_rst_busy", 32'(bsy[0]), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("mid_seq", 32'(sq[0]), 32'd0);
    check("mid_frames", 32'(frm[0]), 32'd0);
    check("mid_drop", 32'(drp[0]), 32'd0);
    sv = 1'b1;
    tick();
    sv = 1'b0;
    check("mid_next_sync", 32'(txd[0]), 32'hA5);
    tick();
    check("mid_next_seq", 32'(txd[0]), 32'h00);
    repeat (12) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gps_nav_frame_tx.md
# gps_nav_frame_tx

Outbound end of the GPS data path. Captures position/velocity samples from the navigation core and serializes each captured sample into an 11-byte framed packet on a valid/ready byte stream toward the host link (UART/USB bridge). It provides optional sample decimation, a per-frame sequence number and checksum, and frame-sent and dropped-sample counters for link health monitoring.

## Interface
- SYNC_BYTE, 8'hA5, first byte of every frame.
- DECIM, 1, send one frame per DECIM accepted sample strobes. Legal range is 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- position  in  32  unsigned position sample. Valid only with sample_valid.
- velocity  in  32  unsigned velocity sample. Valid only with sample_valid.
- sample_valid  in  1  single-cycle strobe: new sample present.
- tx_data  out  8  frame byte.
- tx_valid  out  1  tx_data holds a byte.
- tx_ready  in  1  sink accepts the byte this cycle.
- busy  out  1  a frame is in progress (SEND state).
- seq  out  8  sequence number of the next frame to launch.
- frames_sent  out  16  count of completed frames. Wraps.
- drop_cnt  out  16  count of launch strobes lost while busy. Saturates at 16'hFFFF.

## Operation
- Frame layout, byte index 0..10:
  - byte 0: SYNC_BYTE.
  - byte 1: seq.
  - bytes 2..5: position, MSB first.
  - bytes 6..9: velocity, MSB first.
  - byte 10: checksum = (sum of bytes 1..9) mod 256.
- Decimation counter dcnt has 8 bits and resets to 0.
  - Every sample_valid advances dcnt modulo DECIM, regardless of state.
  - A strobe seen when dcnt==0 is a launch strobe.
- States: IDLE and SEND.
- IDLE:
  - On a launch strobe, latch position, velocity and the current seq into snapshot registers.
  - Set byte index to 0 and go to SEND.
  - Increment seq, wrapping 255 -> 0.
- SEND:
  - Present the byte for the current index with tx_valid=1.
  - On handshake (tx_valid && tx_ready), advance the index.
  - On handshake of byte 10, go to IDLE and increment frames_sent.
- A launch strobe in SEND is dropped:
  - Increment drop_cnt (saturating).
  - Leave the snapshot and seq untouched.
- A launch strobe on the same cycle as the byte-10 handshake counts as busy and is dropped.
- Input samples change under the frame freely; the snapshot guarantees frame content equals the latched values.
- busy = (state == SEND).
- Checksum is computed from the snapshot. It is never affected by live inputs.

## Timing
- Reset values:
  - state IDLE, tx_valid 0, tx_data 8'h00, busy 0.
  - seq 0, frames_sent 0, drop_cnt 0, dcnt 0, snapshot 0.
- All outputs are registered.
- Launch strobe at cycle N in IDLE gives tx_valid=1 and tx_data=SYNC_BYTE at cycle N+1.
- With tx_ready held high, bytes 0..10 go out on consecutive cycles N+1..N+11.
  - tx_valid=0 and state IDLE at N+12.
  - Earliest next launch strobe is N+12.
- Backpressure: while tx_valid && !tx_ready, tx_data and tx_valid hold stable.
- tx_valid never deasserts mid-frame except on reset.
- Reset mid-frame asynchronously clears everything:
  - tx_valid drops immediately.
  - The partial frame is abandoned and is not counted.
  - The next frame restarts at seq 0.
- frames_sent wraps FFFF -> 0000. drop_cnt holds at FFFF.

## Test plan
- Basic frame: DECIM=1, tx_ready=1, position=1000, velocity=5, one strobe. Required byte sequence: A5 00 00 00 03 E8 00 00 00 05 F0 on 11 consecutive cycles starting 1 cycle after the strobe. After completion, frames_sent=1 and seq=1.
- Backpressure: same stimulus with tx_ready toggling 1,0,0,1,... Each byte holds stable while stalled, byte order and content are identical to the basic frame, and frames_sent=1 at the end.
- Drop while busy:
  - Strobe at cycle 0, then strobes at cycles 3 and 11 (byte-10 handshake cycle, tx_ready=1).
  - Required: drop_cnt=2, one frame only, seq=1.
  - Then a strobe at cycle 12 launches frame seq=1.
- Decimation: DECIM=3, 7 strobes spaced 20 cycles apart. Frames launch on strobes 1, 4 and 7 only, with seq 0, 1, 2. drop_cnt=0.
- Sequence wrap: 257 frames. Frame 256 carries seq=FF, frame 257 carries seq=00, and frames_sent=257.
- Reset mid-frame:
  - Assert rst during byte 4 of a frame.
  - Required: tx_valid=0 in the same cycle.
  - All counters are 0 after release.
  - The next frame starts with A5 00.
